// File: rtl/key16.sv
// ---------------------------------------------------------------------------
// key16 -- 4x4 key-matrix scanner with frame debounce and an event queue.
//
// Rows are strobed low one at a time for SCAN_DIV clocks each. The returned
// columns are synchronized, and one nibble is captured per row at the end of
// its phase. Four nibbles make a frame. A frame that repeats DEBOUNCE times in
// a row becomes the debounced key state. Differences between the debounced
// state and what has already been reported are emitted one at a time as
// press/release events, with a valid/ready handshake.
//
// Parameters
//   SCAN_DIV  clocks per row phase (4..65535)
//   DEBOUNCE  identical consecutive frames needed to update keybits (1..255)
//
// Ports
//   clk          clock; all state changes on its rising edge
//   rst_n        asynchronous active-low reset
//   row_drive    active-low row strobe; 4'b1111 while in reset
//   col_sense    active-low column returns (asynchronous, pulled up)
//   keybits      debounced key state, bit row*4+col, 1 = pressed
//   event_valid  an event is pending
//   event_code   key index of the pending event
//   event_press  1 = press, 0 = release
//   event_ready  consumer takes the event when high together with event_valid
//
// Build option
//   KEY16_GHOST_REJECT_EN  when defined, completed frames that contain a
//                          rectangle (possible ghost key) are discarded.
// ---------------------------------------------------------------------------
module key16 #(
  parameter int unsigned SCAN_DIV = 32,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [3:0]  row_drive,
  input  logic [3:0]  col_sense,
  output logic [15:0] keybits,
  output logic        event_valid,
  output logic [3:0]  event_code,
  output logic        event_press,
  input  logic        event_ready
);

  localparam logic [15:0] PHASE_LAST = 16'(SCAN_DIV - 1);
  localparam logic [7:0]  DEB_MAX    = 8'(DEBOUNCE);

  typedef enum logic {
    EV_IDLE,
    EV_PEND
  } ev_state_t;

  // -------------------------------------------------------------------------
  // Column synchronizer. The idle level is all ones (pulled up), so that is
  // also the reset value.
  // -------------------------------------------------------------------------
  logic [3:0] col_s1_q, col_s2_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others; blocking here would chain the two
  // synchronizer stages into one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_s1_q <= 4'hF;
      col_s2_q <= 4'hF;
    end else begin
      col_s1_q <= col_sense;
      col_s2_q <= col_s1_q;
    end
  end

  // -------------------------------------------------------------------------
  // Phase counter and row select.
  // -------------------------------------------------------------------------
  logic [15:0] phase_q;
  logic [1:0]  row_q;
  logic        phase_wrap;
  logic        frame_done;

  assign phase_wrap = (phase_q == PHASE_LAST);
  assign frame_done = phase_wrap && (row_q == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= '0;
      row_q   <= '0;
    end else if (phase_wrap) begin
      phase_q <= '0;
      row_q   <= row_q + 2'd1;
    end else begin
      phase_q <= phase_q + 16'd1;
    end
  end

  // Rows float high during reset. Row 0 is driven as soon as reset is
  // released, which matches the phase counter starting at zero.
  assign row_drive = rst_n ? ~(4'b0001 << row_q) : 4'b1111;

  // -------------------------------------------------------------------------
  // Raw frame assembly. frame_d includes the nibble being captured this
  // cycle, so on frame_done it is the complete new frame.
  // -------------------------------------------------------------------------
  logic [15:0] raw_q, frame_d;

  // NOTE: every combinational output gets a default before any condition, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    frame_d = raw_q;
    if (phase_wrap) begin
      frame_d[{row_q, 2'b00} +: 4] = ~col_s2_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) raw_q <= '0;
    else        raw_q <= frame_d;
  end

  // -------------------------------------------------------------------------
  // Ghost-key filter: two rows that share two or more pressed columns form a
  // rectangle, in which any one of the four keys could be a phantom.
  // -------------------------------------------------------------------------
  logic frame_ok;

`ifdef KEY16_GHOST_REJECT_EN
  function automatic logic has_rect(input logic [15:0] f);
    logic [3:0] m;
    has_rect = 1'b0;
    for (int a = 0; a < 3; a++) begin
      for (int b = a + 1; b < 4; b++) begin
        m = f[a*4 +: 4] & f[b*4 +: 4];
        // Clearing the lowest set bit leaves something only if two were set.
        if ((m & (m - 4'd1)) != 4'd0) has_rect = 1'b1;
      end
    end
  endfunction

  assign frame_ok = !has_rect(frame_d);
`else
  assign frame_ok = 1'b1;
`endif

  // -------------------------------------------------------------------------
  // Frame debounce.
  // -------------------------------------------------------------------------
  logic [15:0] prev_q, prev_d;
  logic [7:0]  stable_q, stable_d;
  logic [15:0] keybits_q, keybits_d;

  always_comb begin
    prev_d   = prev_q;
    stable_d = stable_q;
    if (frame_done && frame_ok) begin
      prev_d = frame_d;
      if (frame_d == prev_q) begin
        stable_d = (stable_q == DEB_MAX) ? stable_q : stable_q + 8'd1;
      end else begin
        stable_d = 8'd1;
      end
    end
  end

  // prev_q holds the frame that produced stable_q, so loading from it one
  // cycle after the count reaches DEBOUNCE gives the debounced frame.
  assign keybits_d = (stable_q == DEB_MAX) ? prev_q : keybits_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q    <= '0;
      stable_q  <= '0;
      keybits_q <= '0;
    end else begin
      prev_q    <= prev_d;
      stable_q  <= stable_d;
      keybits_q <= keybits_d;
    end
  end

  assign keybits = keybits_q;

  // -------------------------------------------------------------------------
  // Event engine. reported_q is the key state the consumer has been told
  // about. An event is selected only while idle, which holds the rate to one
  // per two cycles. Any churn in keybits while an event waits simply changes
  // the difference seen at the next selection, so it coalesces.
  // -------------------------------------------------------------------------
  ev_state_t   state_q, state_d;
  logic [15:0] reported_q, reported_d;
  logic [3:0]  code_q, code_d;
  logic        press_q, press_d;
  logic [15:0] diff;
  logic [3:0]  sel_idx;

  assign diff = keybits_q ^ reported_q;

  // Lowest differing index; scanning downward lets the last hit win.
  always_comb begin
    sel_idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (diff[i]) sel_idx = 4'(i);
    end
  end

  always_comb begin
    state_d    = state_q;
    reported_d = reported_q;
    code_d     = code_q;
    press_d    = press_q;
    unique case (state_q)
      EV_IDLE: begin
        if (diff != 16'd0) begin
          state_d             = EV_PEND;
          code_d              = sel_idx;
          press_d             = keybits_q[sel_idx];
          reported_d[sel_idx] = keybits_q[sel_idx];
        end
      end
      EV_PEND: begin
        if (event_ready) state_d = EV_IDLE;
      end
      default: state_d = EV_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EV_IDLE;
      reported_q <= '0;
      code_q     <= '0;
      press_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      reported_q <= reported_d;
      code_q     <= code_d;
      press_q    <= press_d;
    end
  end

  assign event_valid = (state_q == EV_PEND);
  assign event_code  = code_q;
  assign event_press = press_q;

endmodule

// File: tb/tb_key16.sv
// ---------------------------------------------------------------------------
// tb_key16 -- self-checking bench for key16 (SCAN_DIV=4, DEBOUNCE=3).
//
// A passive diode-less key matrix (with ghosting) drives col_sense from a
// vector of physically pressed keys. Stimulus proceeds a whole scan frame at
// a time; a frame-level model predicts the debounced state and pushes the
// expected events into a queue, which a separate monitor drains on every
// accepted handshake.
// ---------------------------------------------------------------------------
module tb_key16;

  localparam int SD  = 4;
  localparam int DEB = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  row_drive;
  logic [3:0]  col_sense;
  logic [15:0] keybits;
  logic        event_valid;
  logic [3:0]  event_code;
  logic        event_press;
  logic        event_ready = 1'b1;

  logic [15:0] pressed = 16'h0000;
  int          ready_mode = 1;  // 0 = low, 1 = high, 2 = random

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [3:0] code;
    logic       press;
  } ev_t;

  ev_t exp_q[$];

  // Frame-level model state.
  logic [15:0] m_prev;
  int          m_stable;
  logic [15:0] m_kb;

  key16 #(.SCAN_DIV(SD), .DEBOUNCE(DEB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .row_drive   (row_drive),
    .col_sense   (col_sense),
    .keybits     (keybits),
    .event_valid (event_valid),
    .event_code  (event_code),
    .event_press (event_press),
    .event_ready (event_ready)
  );

  always #5 clk = ~clk;

  // Columns electrically tied to row r through pressed switches (no diodes).
  function automatic logic [3:0] net_cols(input logic [15:0] k, input int r);
    logic [3:0] rows;
    logic [3:0] cols;
    rows = 4'b0001 << r;
    cols = 4'b0000;
    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < 4; i++) if (rows[i]) cols = cols | k[i*4 +: 4];
      for (int i = 0; i < 4; i++) if ((k[i*4 +: 4] & cols) != 4'b0000) rows[i] = 1'b1;
    end
    return cols;
  endfunction

  function automatic logic [15:0] scan_frame(input logic [15:0] k);
    logic [15:0] f;
    for (int r = 0; r < 4; r++) f[r*4 +: 4] = net_cols(k, r);
    return f;
  endfunction

  function automatic logic has_rect(input logic [15:0] f);
    for (int a = 0; a < 4; a++)
      for (int b = a + 1; b < 4; b++)
        if ($countones(f[a*4 +: 4] & f[b*4 +: 4]) >= 2) return 1'b1;
    return 1'b0;
  endfunction

  always_comb begin
    col_sense = 4'hF;
    for (int r = 0; r < 4; r++) begin
      if (!row_drive[r]) col_sense = col_sense & ~net_cols(pressed, r);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Debounce rules applied to one completed frame of the given key set.
  task automatic model_frame(input logic [15:0] keys);
    logic [15:0] f;
    ev_t e;
    f = scan_frame(keys);
`ifdef KEY16_GHOST_REJECT_EN
    if (has_rect(f)) return;
`endif
    if (f == m_prev) m_stable = (m_stable < DEB) ? m_stable + 1 : DEB;
    else             m_stable = 1;
    m_prev = f;
    if (m_stable == DEB && f != m_kb) begin
      for (int i = 0; i < 16; i++) begin
        if (f[i] != m_kb[i]) begin
          e.code  = 4'(i);
          e.press = f[i];
          exp_q.push_back(e);
        end
      end
      m_kb = f;
    end
  endtask

  // One full scan frame: keys are applied at the frame start; mid-frame the
  // row strobe and the state debounced from the previous frames are checked.
  task automatic run_frame(input logic [15:0] keys);
    pressed = keys;
    repeat (SD * 2) @(posedge clk);
    #1;
    check("row_mid_frame", {28'd0, row_drive}, 32'hB);
    check("keybits", {16'd0, keybits}, {16'd0, m_kb});
    repeat (SD * 2) @(posedge clk);
    #1;
    model_frame(keys);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    m_prev   = 16'd0;
    m_stable = 0;
    m_kb     = 16'd0;
    exp_q.delete();
    #1;
    check("rst_row_drive", {28'd0, row_drive}, 32'hF);
    check("rst_keybits", {16'd0, keybits}, 32'h0);
    check("rst_event_valid", {31'd0, event_valid}, 32'h0);
    check("rst_event_code", {28'd0, event_code}, 32'h0);
    check("rst_event_press", {31'd0, event_press}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("row0_after_rst", {28'd0, row_drive}, 32'hE);
  endtask

  // Consumer ready, updated just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       event_ready = 1'b0;
        1:       event_ready = 1'b1;
        default: event_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: handshake hold, post-accept gap, and in-order scoreboard.
  initial begin
    logic       hold_v;
    logic       was_acc;
    logic [3:0] h_code;
    logic       h_press;
    ev_t        e;
    hold_v  = 1'b0;
    was_acc = 1'b0;
    h_code  = 4'd0;
    h_press = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_v  = 1'b0;
        was_acc = 1'b0;
      end else begin
        if (hold_v) begin
          check("ev_hold_valid", {31'd0, event_valid}, 32'h1);
          check("ev_hold_code", {28'd0, event_code}, {28'd0, h_code});
          check("ev_hold_press", {31'd0, event_press}, {31'd0, h_press});
        end
        if (was_acc) check("ev_gap_after_accept", {31'd0, event_valid}, 32'h0);
        was_acc = 1'b0;
        if (event_valid && event_ready) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL ev_unexpected: got code %0d press %0d, expected no event",
                     event_code, event_press);
          end else begin
            e = exp_q.pop_front();
            check("ev_code", {28'd0, event_code}, {28'd0, e.code});
            check("ev_press", {31'd0, event_press}, {31'd0, e.press});
          end
          was_acc = 1'b1;
        end
        hold_v  = event_valid && !event_ready;
        h_code  = event_code;
        h_press = event_press;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] keys;
    logic [15:0] exp_ghost;
    int nk;
    int hold;

    ready_mode = 1;
    do_reset();

    // Key 6 held from reset, then released.
    repeat (2) run_frame(16'h0040);
    check("k6_not_yet", {16'd0, keybits}, 32'h0);
    repeat (2) run_frame(16'h0040);
    check("k6_pressed", {16'd0, keybits}, 32'h0040);
    repeat (4) run_frame(16'h0000);
    check("k6_released", {16'd0, keybits}, 32'h0);

    // Keys 1, 9, 15 with the consumer stalled, then drained in order.
    ready_mode = 0;
    repeat (4) run_frame(16'h8202);
    check("bp_valid", {31'd0, event_valid}, 32'h1);
    check("bp_code", {28'd0, event_code}, 32'h1);
    check("bp_press", {31'd0, event_press}, 32'h1);
    ready_mode = 1;
    repeat (2) run_frame(16'h8202);
    check("bp_keybits", {16'd0, keybits}, 32'h8202);
    repeat (4) run_frame(16'h0000);

    // Key 3 bouncing on alternate frames never debounces.
    for (int i = 0; i < 10; i++) run_frame((i % 2 == 0) ? 16'h0008 : 16'h0000);
    repeat (3) run_frame(16'h0000);
    check("bounce_keybits", {16'd0, keybits}, 32'h0);

    // Keys 0, 1, 4 produce a ghost at key 5.
`ifdef KEY16_GHOST_REJECT_EN
    exp_ghost = 16'h0000;
`else
    exp_ghost = 16'h0033;
`endif
    repeat (4) run_frame(16'h0013);
    check("ghost_keybits", {16'd0, keybits}, {16'd0, exp_ghost});
    repeat (4) run_frame(16'h0000);

    // Reset with an event pending mid-frame: the event is dropped.
    ready_mode = 0;
    repeat (3) run_frame(16'h0040);
    repeat (10) @(posedge clk);
    #1;
    check("pend_before_rst", {31'd0, event_valid}, 32'h1);
    pressed = 16'h0000;
    do_reset();
    ready_mode = 1;
    repeat (4) run_frame(16'h0000);
    check("post_rst_keybits", {16'd0, keybits}, 32'h0);

    // Randomized key sets and hold times with a randomly stalling consumer.
    ready_mode = 2;
    for (int g = 0; g < 40; g++) begin
      keys = 16'h0000;
      nk = $urandom_range(0, 2);
      for (int j = 0; j < nk; j++) keys[$urandom_range(0, 15)] = 1'b1;
      hold = $urandom_range(1, 5);
      for (int j = 0; j < hold; j++) run_frame(keys);
    end

    ready_mode = 1;
    repeat (5) run_frame(16'h0000);
    check("ev_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/key16.md
KEY16 -- requirements
Module: key16

Interface
REQ-001 SCAN_DIV, default 32: clock cycles per row phase; legal range 4..65535.
REQ-002 DEBOUNCE, default 4: consecutive identical scan frames required before the debounced state updates; legal range 1..255.
REQ-003 clk  input  1  single clock; all state on posedge clk.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 row_drive  output  4  active-low row strobe; exactly one bit low outside reset.
REQ-006 col_sense  input  4  active-low column returns, externally pulled up, asynchronous to clk.
REQ-007 keybits  output  16  debounced key state, 1 = pressed; bit index = row*4 + col.
REQ-008 event_valid  output  1  key event pending.
REQ-009 event_code  output  4  key index of the pending event.
REQ-010 event_press  output  1  1 = press, 0 = release.
REQ-011 event_ready  input  1  consumer accepts the event when high together with event_valid.

Function
REQ-012 col_sense shall pass through a 2-flop synchronizer before any use.
REQ-013 Phase counter shall count 0..SCAN_DIV-1 and then wrap; row index shall advance 0→1→2→3→0 on each wrap.
REQ-014 row_drive shall be 4'b1110, 4'b1101, 4'b1011 and 4'b0111 for rows 0, 1, 2 and 3 respectively.
REQ-015 In the cycle where the phase count equals SCAN_DIV-1, the inverted synchronized columns shall be captured into raw frame bits [row*4+3 : row*4].
REQ-016 At the end of the row-3 phase a frame completes; the raw frame is compared with the previous completed frame.
REQ-017 Frame equal to the previous frame: stable counter increments, saturating at DEBOUNCE. Frame differs: counter set to 1.
REQ-018 When the stable counter equals DEBOUNCE, keybits shall be loaded with the frame in the following cycle.
REQ-019 An internal reported register shall track the state already signalled as events.
REQ-020 When event_valid=0 and keybits≠reported, the engine shall select the lowest differing index i. Next cycle: event_valid=1, event_code=i, event_press=keybits[i], and reported[i] updated.
REQ-021 event_valid, event_code and event_press shall hold stable until the cycle where event_valid && event_ready is sampled high; event_valid drops in the next cycle.
REQ-022 Maximum event rate shall be one event per two cycles.
REQ-023 Under backpressure, further changes shall coalesce. A key that toggles twice before its index is selected yields no event. No event is ever lost or duplicated relative to the final keybits.
REQ-024 A keybits change during a pending event shall not alter the held event fields.

Reset
REQ-025 While rst_n=0: row_drive=4'b1111, keybits=0, reported=0, event_valid=0, event_code=0, event_press=0, and all counters and the raw frame register cleared.
REQ-026 After rst_n rises, row 0 shall be driven in the first cycle, phase count starting at 0.
REQ-027 Reset asserted mid-frame or with an event pending shall discard the partial frame and the pending event without emitting it.

Configuration
REQ-028 Macro KEY16_GHOST_REJECT_EN compiles in ghost-key rejection.
REQ-029 With the macro defined, a completed frame containing any rectangle shall be discarded: keybits and the stable counter hold, and the previous-frame register is not updated. A rectangle is two rows r1≠r2 and two columns c1≠c2 with all four bits set.
REQ-030 Without the macro, every frame shall be processed per REQ-016..REQ-018.

Verification (SCAN_DIV=4, DEBOUNCE=3)
REQ-031 Key 6 (row 1, col 2) held low from reset -> keybits=16'h0040 exactly 3 frames after the first frame containing it; one event with code 6, press 1.
REQ-032 Key 6 released after REQ-031 -> keybits returns to 0 after 3 frames; one event with code 6, press 0.
REQ-033 Keys 1, 9 and 15 pressed together with event_ready=0 -> event_valid held with code 1. Releasing ready gives codes 1, 9, 15 in order, each press 1.
REQ-034 Key 3 bounced on alternate frames for 10 frames, then released -> keybits stays 0 and no event is produced.
REQ-035 Keys 0, 1 and 4 pressed (4-key ghost at 5), macro defined -> keybits stays 0. Macro undefined -> keybits=16'h0033.
REQ-036 rst_n pulsed low mid-frame with an event pending -> all outputs match REQ-025 and no event is emitted; the scan restarts at row_drive=4'b1110.
